fifo_unpacker: RTL and testbench
================================

// Module: fifo_unpacker
// PURPOSE
//  Read-side consumer of the 140-bit async FIFO, in the clk_out domain.
//  Pops one word whenever the FIFO is non-empty and the block is idle.
//  Decodes the header {chan, len}, then emits the payload as a byte stream
//  with a valid/ready handshake and SOF/EOF framing.
//  Drops malformed words and reports them on a one-cycle error pulse.
// PARAMETERS
//  DW      140  FIFO word width; fixed layout, bits as listed below
//  NBYTES  16   payload bytes per word (128 bits)
//  CW      4    channel id width
//  LW      8    length field width
// PORTS
//  clk_out         in   1    read-domain clock, rising edge
//  rst_n           in   1    asynchronous reset, active low
//  fifo_empty      in   1    FIFO empty flag
//  fifo_r_enable   out  1    FIFO pop strobe; data_from_fifo is valid the cycle after
//  data_from_fifo  in   140  [139:136] chan, [135:128] len, [127:0] payload; byte0=[127:120]
//  out_data        out  8    current payload byte
//  out_valid       out  1    out_data/out_sof/out_eof/out_chan are valid
//  out_ready       in   1    downstream accepts the byte when out_valid&&out_ready
//  out_sof         out  1    first byte of a word
//  out_eof         out  1    last byte of a word (index len-1)
//  out_chan        out  4    chan field of the word in flight
//  len_err         out  1    1-cycle pulse: word dropped, len==0 or len>16
//  busy            out  1    high in any state except IDLE
// BEHAVIOUR
//  Reset (async assert, sync deassert by use): state=IDLE; all outputs 0; word/byte index cleared.
//  FSM states: IDLE, POP, LOAD, SEND.
//   IDLE: if !fifo_empty -> POP.
//   POP: fifo_r_enable=1 for exactly one cycle -> LOAD. Never asserted while fifo_empty=1.
//   LOAD: capture data_from_fifo into a 140-bit holding register.
//     If len in 1..16 -> SEND with idx=0. Otherwise pulse len_err and go to IDLE.
//   SEND: out_valid=1; out_data=payload byte idx; out_sof=(idx==0); out_eof=(idx==len-1).
//     On a handshake: if eof -> IDLE, else idx++.
//     No handshake: outputs hold, AXI-style. out_valid never drops before acceptance.
//  Latency: fifo_empty falls at edge N -> fifo_r_enable high in cycle N+1
//   -> first out_valid in cycle N+3.
//  Throughput: 1 byte/cycle inside a word. Between words there are 3 idle cycles
//   (IDLE/POP/LOAD); no prefetch.
//  out_chan is taken from the holding register and is stable for the whole word.
//  Single-byte word (len=1): out_sof and out_eof are both high on the same byte.
//  fifo_empty toggling during SEND is ignored; it is only sampled in IDLE.
//  Async reset mid-word: the remainder is discarded, out_valid drops immediately,
//   and the word is not re-popped.
//  out_ready high with out_valid low has no effect.
//  len_err and out_valid are never high in the same cycle.
// CONFIGURATION
//  UNPACK_ERR_CNT_EN defined: adds an output err_cnt [7:0].
//   Increments on each len_err, saturates at 8'hFF, clears on reset.
//  UNPACK_ERR_CNT_EN undefined: no err_cnt port and no counter logic.
//   len_err behaves identically in both builds.
// TESTING
//  Test 1: reset with fifo_empty=1 for 4 cycles.
//   -> all outputs 0, fifo_r_enable never asserted, busy=0.
//  Test 2: one word, chan=3, len=4, payload bytes 11,22,33,44, out_ready=1.
//   -> 4 beats: 11(sof),22,33,44(eof); out_chan=3; exactly one pop; back to IDLE.
//  Test 3: same word, out_ready toggles 1,0,0,1,0,1,1.
//   -> 4 beats in order; no byte lost or duplicated; outputs stable while stalled.
//  Test 4: len=0, then len=17, then a valid len=16 word.
//   -> two len_err pulses; third word emits 16 bytes;
//      err_cnt=2 when UNPACK_ERR_CNT_EN is defined.
//  Test 5: len=1 word. -> a single beat with out_sof=out_eof=1.
//  Test 6: 3 back-to-back words with reset pulsed during byte 5 of word 2.
//   -> out_valid drops at once; no pop while fifo_empty=1;
//      the scoreboard queue matches all bytes that were accepted.

Source files
------------

// File: rtl/fifo_unpacker_if.sv
// Byte-stream handshake bundle driven by fifo_unpacker: data, valid/ready, SOF/EOF framing and channel id.
interface fifo_unpacker_if #(
  parameter int unsigned CW = 4
);
  logic [7:0]    data;
  logic          valid;
  logic          ready;
  logic          sof;
  logic          eof;
  logic [CW-1:0] chan;

  modport master (output data, valid, sof, eof, chan, input ready);
  modport slave  (input data, valid, sof, eof, chan, output ready);
endinterface

// File: rtl/fifo_unpacker.sv
// Read-side consumer of the 140-bit async FIFO: pops a word, checks its length and streams the payload bytes.
// Optional macro UNPACK_ERR_CNT_EN adds a saturating 8-bit count of dropped words on err_cnt.
module fifo_unpacker #(
  parameter int unsigned DW     = 140,
  parameter int unsigned NBYTES = 16,
  parameter int unsigned CW     = 4,
  parameter int unsigned LW     = 8
) (
  input  logic          clk_out,
  input  logic          rst_n,
  input  logic          fifo_empty,
  output logic          fifo_r_enable,
  input  logic [DW-1:0] data_from_fifo,
  fifo_unpacker_if.master out,
  output logic          len_err,
`ifdef UNPACK_ERR_CNT_EN
  output logic [7:0]    err_cnt,
`endif
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, POP, LOAD, SEND} state_t;

  state_t                state, state_next;
  logic [DW-1:0]         hold;
  logic                  hold_en;
  logic [3:0]            idx, idx_next;
  logic [LW-1:0]         in_len, hold_len;
  logic                  in_len_ok;
  logic                  idx_last;
  logic [8*NBYTES-1:0]   payload;
  logic [6:0]            bit_base;

  assign in_len    = data_from_fifo[DW-CW-1 -: LW];
  assign in_len_ok = (in_len != '0) && (in_len <= LW'(NBYTES));
  assign hold_len  = hold[DW-CW-1 -: LW];
  assign payload   = hold[8*NBYTES-1:0];
  assign idx_last  = ({4'b0000, idx} == (hold_len - 8'd1));

  // Byte 0 sits in the top lane, so the lane base is (15 - idx) * 8.
  assign bit_base  = {~idx, 3'b000};

  assign out.data  = payload[bit_base +: 8];
  assign out.chan  = hold[DW-1 -: CW];
  assign out.sof   = (state == SEND) && (idx == '0);
  assign out.eof   = (state == SEND) && idx_last;
  assign busy      = (state != IDLE);

  always_comb begin
    state_next    = state;
    idx_next      = idx;
    hold_en       = 1'b0;
    fifo_r_enable = 1'b0;
    len_err       = 1'b0;
    out.valid     = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) state_next = POP;
      end
      POP: begin
        fifo_r_enable = 1'b1;
        state_next    = LOAD;
      end
      LOAD: begin
        hold_en = 1'b1;
        if (in_len_ok) begin
          state_next = SEND;
          idx_next   = '0;
        end else begin
          len_err    = 1'b1;
          state_next = IDLE;
        end
      end
      SEND: begin
        out.valid = 1'b1;
        if (out.ready) begin
          if (idx_last) state_next = IDLE;
          else          idx_next   = idx + 4'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= '0;
      hold  <= '0;
    end else begin
      state <= state_next;
      idx   <= idx_next;
      if (hold_en) hold <= data_from_fifo;
    end
  end

`ifdef UNPACK_ERR_CNT_EN
  always_ff @(posedge clk_out or negedge rst_n) begin
    if (!rst_n)                         err_cnt <= '0;
    else if (len_err && err_cnt != '1)  err_cnt <= err_cnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_fifo_unpacker.sv
// Directed bench for fifo_unpacker: FIFO model feeding words, scoreboard of expected bytes checked on each handshake.
module tb_fifo_unpacker;

  logic         clk_out = 1'b0;
  logic         rst_n;
  logic         fifo_empty;
  logic         fifo_r_enable;
  logic [139:0] data_from_fifo;
  logic         len_err;
  logic         busy;
`ifdef UNPACK_ERR_CNT_EN
  logic [7:0]   err_cnt;
`endif

  always #5 clk_out = ~clk_out;

  fifo_unpacker_if #(.CW(4)) bus ();

  fifo_unpacker #(.DW(140), .NBYTES(16), .CW(4), .LW(8)) dut (
    .clk_out        (clk_out),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_r_enable  (fifo_r_enable),
    .data_from_fifo (data_from_fifo),
    .out            (bus),
    .len_err        (len_err),
`ifdef UNPACK_ERR_CNT_EN
    .err_cnt        (err_cnt),
`endif
    .busy           (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       sof;
    logic       eof;
    logic [3:0] chan;
    int         wid;
    int         idx;
  } beat_t;

  beat_t        sb[$];
  logic [139:0] fifo_q[$];
  bit           ready_pat[$];

  int checks   = 0;
  int failures = 0;
  int wid_ctr  = 0;
  int pops     = 0;
  int err_seen = 0;
  int rst_wid  = 0;
  int rst_idx  = 0;
  bit rst_done = 1'b0;
  bit ready_dflt = 1'b1;
  logic s_ren, s_valid, s_busy;
  bit prev_stall = 1'b0;
  logic [13:0] prev_beat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [3:0] chan, input logic [7:0] len,
                           input logic [7:0] base, input logic [7:0] step);
    logic [139:0] w;
    logic [7:0]   b;
    w = '0;
    w[139:136] = chan;
    w[135:128] = len;
    b = base;
    for (int i = 0; i < 16; i++) begin
      w[127-8*i -: 8] = b;
      b = b + step;
    end
    wid_ctr++;
    fifo_q.push_back(w);
    fifo_empty = 1'b0;
    if (len >= 8'd1 && len <= 8'd16) begin
      b = base;
      for (int i = 0; i < int'(len); i++) begin
        sb.push_back('{data: b, sof: (i == 0), eof: (i == int'(len) - 1),
                       chan: chan, wid: wid_ctr, idx: i});
        b = b + step;
      end
    end
  endtask

  task automatic cycle();
    beat_t e;
    @(negedge clk_out);
    if (bus.valid && ready_pat.size() != 0) bus.ready = ready_pat.pop_front();
    else                                    bus.ready = ready_dflt;
    s_ren   = fifo_r_enable;
    s_valid = bus.valid;
    s_busy  = busy;
    if (bus.valid || len_err) check("valid_err_excl", {31'd0, bus.valid & len_err}, 32'd0);
    if (len_err) err_seen++;
    if (prev_stall) check("stall_hold", {18'd0, bus.data, bus.sof, bus.eof, bus.chan}, {18'd0, prev_beat});

    if (rst_wid != 0 && bus.valid && sb.size() != 0 && sb[0].wid == rst_wid && sb[0].idx == rst_idx) begin
      #2 rst_n = 1'b0;
      #1;
      check("rst_valid_drop", {31'd0, bus.valid}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_sof", {31'd0, bus.sof}, 32'd0);
      while (sb.size() != 0 && sb[0].wid == rst_wid) void'(sb.pop_front());
      rst_wid    = 0;
      rst_done   = 1'b1;
      prev_stall = 1'b0;
      @(negedge clk_out);
      rst_n = 1'b1;
      return;
    end

    if (bus.valid && bus.ready) begin
      check("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("beat_data", {24'd0, bus.data}, {24'd0, e.data});
        check("beat_sof",  {31'd0, bus.sof},  {31'd0, e.sof});
        check("beat_eof",  {31'd0, bus.eof},  {31'd0, e.eof});
        check("beat_chan", {28'd0, bus.chan}, {28'd0, e.chan});
      end
    end
    prev_stall = bus.valid && !bus.ready;
    prev_beat  = {bus.data, bus.sof, bus.eof, bus.chan};

    if (fifo_r_enable) begin
      check("pop_nonempty", {31'd0, fifo_empty}, 32'd0);
      pops++;
      @(posedge clk_out);
      #1;
      if (fifo_q.size() != 0) data_from_fifo = fifo_q.pop_front();
      fifo_empty = (fifo_q.size() == 0);
    end
  endtask

  task automatic run_until_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      cycle();
      if (sb.size() == 0 && fifo_q.size() == 0 && !s_busy) done = 1'b1;
    end
    check("drain", {31'd0, done}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, e0;
    rst_n          = 1'b0;
    fifo_empty     = 1'b1;
    bus.ready      = 1'b0;
    data_from_fifo = '0;

    // Test 1: reset, then idle with an empty FIFO
    repeat (2) @(negedge clk_out);
    check("rst_out_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_ren",       {31'd0, fifo_r_enable}, 32'd0);
    check("rst_busy",      {31'd0, busy}, 32'd0);
    check("rst_len_err",   {31'd0, len_err}, 32'd0);
    check("rst_outs",      {18'd0, bus.data, bus.sof, bus.eof, bus.chan}, 32'd0);
`ifdef UNPACK_ERR_CNT_EN
    check("rst_err_cnt",   {24'd0, err_cnt}, 32'd0);
`endif
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      check("idle_ren",  {31'd0, s_ren}, 32'd0);
      check("idle_busy", {31'd0, s_busy}, 32'd0);
    end

    // Test 2: one 4-byte word, latency and single pop
    p0 = pops;
    push_word(4'd3, 8'd4, 8'h11, 8'h11);
    cycle();
    check("lat_pop", {31'd0, s_ren}, 32'd1);
    cycle();
    check("lat_load", {31'd0, s_valid}, 32'd0);
    cycle();
    check("lat_first_valid", {31'd0, s_valid}, 32'd1);
    run_until_idle(50);
    check("t2_pops", pops - p0, 32'd1);

    // Test 3: same word under backpressure
    ready_pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    push_word(4'd3, 8'd4, 8'h11, 8'h11);
    run_until_idle(50);
    check("t3_pattern_used", ready_pat.size(), 32'd0);

    // Test 4: len=0 and len=17 dropped, then a full 16-byte word
    e0 = err_seen;
    push_word(4'd5, 8'd0,  8'h01, 8'h01);
    push_word(4'd6, 8'd17, 8'h40, 8'h01);
    push_word(4'd7, 8'd16, 8'h80, 8'h03);
    run_until_idle(100);
    check("t4_len_err_pulses", err_seen - e0, 32'd2);
`ifdef UNPACK_ERR_CNT_EN
    check("t4_err_cnt", {24'd0, err_cnt}, 32'd2);
`endif

    // Test 5: single-byte word
    push_word(4'd9, 8'd1, 8'hA5, 8'h01);
    run_until_idle(50);

    // Test 6: three words, reset during byte 5 of the second
    e0 = err_seen;
    push_word(4'd1, 8'd8, 8'h20, 8'h01);
    push_word(4'd2, 8'd8, 8'h50, 8'h02);
    push_word(4'd4, 8'd8, 8'hC0, 8'h05);
    rst_wid  = wid_ctr - 1;
    rst_idx  = 4;
    rst_done = 1'b0;
    run_until_idle(200);
    check("t6_rst_fired", {31'd0, rst_done}, 32'd1);
    check("t6_sb_empty", sb.size(), 32'd0);
    check("t6_no_err", err_seen - e0, 32'd0);
`ifdef UNPACK_ERR_CNT_EN
    check("t6_err_cnt_cleared", {24'd0, err_cnt}, 32'd0);
`endif
    check("total_pops", pops, 32'd9);
    check("final_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
